// File: rtl/operand_fetch.sv
// operand_fetch: general register file plus a single-slot operand stage that
// presents an operand pair to the ALU under a valid/ready handshake.
// Optional feature macro: OPERAND_FWD_EN enables a same-cycle write-to-read
// bypass for each captured operand independently.
module operand_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_COUNT  = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic                  in_wr_en,
    input  logic [ADDR_WIDTH-1:0] in_wr_addr,
    input  logic [DATA_WIDTH-1:0] in_wr_data,
    input  logic                  in_req_valid,
    output logic                  out_req_ready,
    input  logic [ADDR_WIDTH-1:0] in_src_addr_1,
    input  logic [ADDR_WIDTH-1:0] in_src_addr_2,
    output logic [DATA_WIDTH-1:0] out_operand_1,
    output logic [DATA_WIDTH-1:0] out_operand_2,
    output logic                  out_operand_valid,
    input  logic                  in_operand_ready
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    // R0 has no storage; it is synthesised as a constant zero on read.
    logic [DATA_WIDTH-1:0] r_regs [1:REG_COUNT-1];
    logic [0:0]            r_state;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] r_op2;

    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    // Ready never looks at in_req_valid, so no valid->ready loop can form upstream.
    assign out_req_ready     = (r_state == S_EMPTY) | in_operand_ready;
    assign w_accept          = in_req_valid & out_req_ready;
    assign out_operand_valid = (r_state == S_FULL);
    assign out_operand_1     = r_op1;
    assign out_operand_2     = r_op2;

    // Read both source registers; address 0 falls through to the zero default.
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            if (in_src_addr_1 == ADDR_WIDTH'(i)) w_rd1 = r_regs[i];
            if (in_src_addr_2 == ADDR_WIDTH'(i)) w_rd2 = r_regs[i];
        end
`ifdef OPERAND_FWD_EN
        // A write landing this edge wins over the stale array contents.
        if (in_wr_en && (in_wr_addr == in_src_addr_1) && (in_src_addr_1 != '0))
            w_rd1 = in_wr_data;
        if (in_wr_en && (in_wr_addr == in_src_addr_2) && (in_src_addr_2 != '0))
            w_rd2 = in_wr_data;
`endif
    end

    // Writeback port: writes continue regardless of the operand slot state.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 1; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else if (in_wr_en) begin
            for (int i = 1; i < REG_COUNT; i++) begin
                if (in_wr_addr == ADDR_WIDTH'(i)) r_regs[i] <= in_wr_data;
            end
        end
    end

    // Operand slot: load on accept, drain on consume, otherwise hold a snapshot.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state <= S_EMPTY;
            r_op1   <= '0;
            r_op2   <= '0;
        end else if (w_accept) begin
            r_state <= S_FULL;
            r_op1   <= w_rd1;
            r_op2   <= w_rd2;
        end else if (in_operand_ready) begin
            r_state <= S_EMPTY;
        end
    end

endmodule
